// File: rtl/feature_map_streamer_pkg.sv
// Shared definitions for the feature-map streamers: FSM states, counter width
// and the flat element index used to address a packed map buffer.
package feature_map_streamer_pkg;

   localparam int DIM_W = 8;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } stream_state_t;

   // The row stride is the buffer's maximum width, not the width of the current map.
   function automatic int elem_idx(input logic [DIM_W-1:0] r,
                                   input logic [DIM_W-1:0] c,
                                   input int               w);
      return int'(r) * w + int'(c);
   endfunction

endpackage

// File: rtl/feature_map_streamer_elem_select.sv
// Wide combinational mux that picks element (row,col) out of the held map buffer.
module fm_elem_select
   import feature_map_streamer_pkg::*;
#(
   parameter int ELEM_WIDTH     = 8,
   parameter int MAX_IMG_HEIGHT = 32,
   parameter int MAX_IMG_WIDTH  = 32
) (
   input  logic [MAX_IMG_HEIGHT*MAX_IMG_WIDTH*ELEM_WIDTH-1:0] map_buf,
   input  logic [DIM_W-1:0]                                   row,
   input  logic [DIM_W-1:0]                                   col,
   output logic [ELEM_WIDTH-1:0]                              elem
);

   localparam int NUM_ELEMS = MAX_IMG_HEIGHT * MAX_IMG_WIDTH;
   localparam int IDX_W     = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;

   logic [ELEM_WIDTH-1:0] elems [NUM_ELEMS];
   int                    flat_idx;

   for (genvar i = 0; i < NUM_ELEMS; i++) begin : g_unpack
      assign elems[i] = map_buf[i*ELEM_WIDTH +: ELEM_WIDTH];
   end

   always_comb begin
      flat_idx = elem_idx(row, col, MAX_IMG_WIDTH);
      elem     = '0;
      if (flat_idx < NUM_ELEMS) begin
         elem = elems[IDX_W'(flat_idx)];
      end
   end

endmodule

// File: rtl/feature_map_streamer.sv
// Captures a full feature map in one cycle and replays it one element per beat,
// row-major, on a valid/ready stream with m_last on the final element.
module feature_map_streamer
   import feature_map_streamer_pkg::*;
#(
   parameter int ELEM_WIDTH     = 8,
   parameter int MAX_IMG_HEIGHT = 32,
   parameter int MAX_IMG_WIDTH  = 32
) (
   input  logic                                               clk,
   input  logic                                               rst_n,
   input  logic                                               cap_valid,
   input  logic [MAX_IMG_HEIGHT*MAX_IMG_WIDTH*ELEM_WIDTH-1:0] cap_data,
   input  logic [7:0]                                         cap_height,
   input  logic [7:0]                                         cap_width,
   output logic                                               m_valid,
   input  logic                                               m_ready,
   output logic [ELEM_WIDTH-1:0]                              m_data,
   output logic                                               m_last,
   output logic                                               busy,
   output logic                                               frame_done,
   output logic                                               err_dim,
   output logic                                               err_overrun,
   input  logic                                               err_clr
);

   localparam int MAP_BITS = MAX_IMG_HEIGHT * MAX_IMG_WIDTH * ELEM_WIDTH;

   stream_state_t         state;
   logic [MAP_BITS-1:0]   map_buf;
   logic [DIM_W-1:0]      h_reg;
   logic [DIM_W-1:0]      w_reg;
   logic [DIM_W-1:0]      row;
   logic [DIM_W-1:0]      col;
   logic [ELEM_WIDTH-1:0] sel_elem;
   logic                  dims_ok;
   logic                  handshake;
   logic                  last_pos;
   logic                  final_hs;
   logic                  accept;
   logic                  err_dim_set;
   logic                  err_over_set;

   fm_elem_select #(
      .ELEM_WIDTH     (ELEM_WIDTH),
      .MAX_IMG_HEIGHT (MAX_IMG_HEIGHT),
      .MAX_IMG_WIDTH  (MAX_IMG_WIDTH)
   ) u_elem_select (
      .map_buf (map_buf),
      .row     (row),
      .col     (col),
      .elem    (sel_elem)
   );

   // A capture is accepted when idle or on the very cycle the last beat leaves,
   // since the buffer is free from that edge onward.
   always_comb begin
      dims_ok      = (cap_height != '0) && (cap_height <= DIM_W'(MAX_IMG_HEIGHT)) &&
                     (cap_width  != '0) && (cap_width  <= DIM_W'(MAX_IMG_WIDTH));
      handshake    = m_valid && m_ready;
      last_pos     = (row == h_reg - 1'b1) && (col == w_reg - 1'b1);
      final_hs     = handshake && last_pos;
      accept       = cap_valid && dims_ok && ((state == IDLE) || final_hs);
      err_dim_set  = cap_valid && !dims_ok && ((state == IDLE) || final_hs);
      err_over_set = cap_valid && (state == STREAM) && !final_hs;
   end

   assign m_valid = (state == STREAM);
   assign busy    = (state == STREAM);
   assign m_last  = m_valid && last_pos;
   assign m_data  = m_valid ? sel_elem : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         h_reg      <= '0;
         w_reg      <= '0;
         row        <= '0;
         col        <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= (state == STREAM) && final_hs;
         if (accept) begin
            state <= STREAM;
            h_reg <= cap_height;
            w_reg <= cap_width;
            row   <= '0;
            col   <= '0;
         end else if ((state == STREAM) && handshake) begin
            if (last_pos) begin
               state <= IDLE;
            end else if (col == w_reg - 1'b1) begin
               col <= '0;
               row <= row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   // The map buffer is deliberately not reset; its contents only matter after a capture.
   always_ff @(posedge clk) begin
      if (accept) begin
         map_buf <= cap_data;
      end
   end

   // A new error event outranks a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_dim     <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         if (err_dim_set)      err_dim <= 1'b1;
         else if (err_clr)     err_dim <= 1'b0;
         if (err_over_set)     err_overrun <= 1'b1;
         else if (err_clr)     err_overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_feature_map_streamer.sv
// Scoreboard bench for feature_map_streamer: captures push expected beats, a
// negedge monitor pops and compares on every handshake.
module tb_feature_map_streamer;

   localparam int EW       = 8;
   localparam int MH       = 32;
   localparam int MW       = 32;
   localparam int MAP_BITS = MH * MW * EW;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                cap_valid;
   logic [MAP_BITS-1:0] cap_data;
   logic [7:0]          cap_height;
   logic [7:0]          cap_width;
   logic                m_valid;
   logic                m_ready;
   logic [EW-1:0]       m_data;
   logic                m_last;
   logic                busy;
   logic                frame_done;
   logic                err_dim;
   logic                err_overrun;
   logic                err_clr;

   logic [EW:0]   sb [$];
   int            checks      = 0;
   int            failures    = 0;
   int            frame_count = 0;
   int            hs_count    = 0;
   logic          stall_prev  = 1'b0;
   logic [EW-1:0] prev_data   = '0;
   logic          prev_last   = 1'b0;
   bit            ready_pat [8] = '{1, 0, 0, 1, 0, 1, 1, 1};

   always #5 clk = ~clk;

   feature_map_streamer #(
      .ELEM_WIDTH     (EW),
      .MAX_IMG_HEIGHT (MH),
      .MAX_IMG_WIDTH  (MW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cap_valid   (cap_valid),
      .cap_data    (cap_data),
      .cap_height  (cap_height),
      .cap_width   (cap_width),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .m_last      (m_last),
      .busy        (busy),
      .frame_done  (frame_done),
      .err_dim     (err_dim),
      .err_overrun (err_overrun),
      .err_clr     (err_clr)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   function automatic logic [EW-1:0] mapVal(input int kind, input int r, input int c);
      int v;
      case (kind)
         0:       v = 10 * r + c;
         1:       v = 'hA5;
         default: v = 'h80 + r * 4 + c;
      endcase
      return v[EW-1:0];
   endfunction

   // Cells outside the valid region carry 0xEE so a wrong stride shows up as bad data.
   task automatic applyStimulus(input int h, input int w, input int kind, input bit expect_accept);
      logic [MAP_BITS-1:0] tmp;
      tmp = '0;
      for (int r = MH - 1; r >= 0; r--) begin
         for (int c = MW - 1; c >= 0; c--) begin
            tmp = {tmp[MAP_BITS-EW-1:0], ((r < h && c < w) ? mapVal(kind, r, c) : EW'(8'hEE))};
         end
      end
      cap_data   = tmp;
      cap_height = 8'(h);
      cap_width  = 8'(w);
      cap_valid  = 1'b1;
      if (expect_accept) begin
         for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
               sb.push_back({(r == h - 1 && c == w - 1), mapVal(kind, r, c)});
            end
         end
      end
      @(posedge clk); #1;
      cap_valid = 1'b0;
   endtask

   task automatic waitIdle(input int budget);
      int n = 0;
      while ((busy || m_valid) && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("idle_timeout", 32'(busy || m_valid), 0);
      @(posedge clk); #1;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_done) frame_count++;
         if (stall_prev) begin
            checkOutput("stall_valid", 32'(m_valid), 1);
            checkOutput("stall_data", 32'(m_data), 32'(prev_data));
            checkOutput("stall_last", 32'(m_last), 32'(prev_last));
         end
         if (m_valid && m_ready) begin
            hs_count++;
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_beat: got data %0h with no beat expected", m_data);
            end else begin
               logic [EW:0] exp_beat;
               exp_beat = sb.pop_front();
               checkOutput("beat_data", 32'(m_data), 32'(exp_beat[EW-1:0]));
               checkOutput("beat_last", 32'(m_last), 32'(exp_beat[EW]));
            end
         end
         stall_prev = m_valid && !m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
      end else begin
         stall_prev = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout: got no finish expected finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int fc0;
      int hs0;
      rst_n      = 1'b0;
      cap_valid  = 1'b0;
      cap_data   = '0;
      cap_height = '0;
      cap_width  = '0;
      m_ready    = 1'b1;
      err_clr    = 1'b0;
      tick(2);
      checkOutput("reset_m_valid", 32'(m_valid), 0);
      checkOutput("reset_m_last", 32'(m_last), 0);
      checkOutput("reset_m_data", 32'(m_data), 0);
      checkOutput("reset_busy", 32'(busy), 0);
      checkOutput("reset_frame_done", 32'(frame_done), 0);
      checkOutput("reset_err_dim", 32'(err_dim), 0);
      checkOutput("reset_err_overrun", 32'(err_overrun), 0);
      rst_n = 1'b1;
      tick(1);

      $display("[TB] basic 2x3 map");
      fc0 = frame_count;
      applyStimulus(2, 3, 0, 1);
      checkOutput("t1_first_valid", 32'(m_valid), 1);
      checkOutput("t1_first_data", 32'(m_data), 0);
      checkOutput("t1_first_last", 32'(m_last), 0);
      tick(5);
      checkOutput("t1_last_data", 32'(m_data), 12);
      checkOutput("t1_last_flag", 32'(m_last), 1);
      tick(1);
      checkOutput("t1_frame_done", 32'(frame_done), 1);
      checkOutput("t1_valid_after", 32'(m_valid), 0);
      tick(1);
      checkOutput("t1_frame_done_off", 32'(frame_done), 0);
      checkOutput("t1_frame_count", 32'(frame_count - fc0), 1);

      $display("[TB] backpressure");
      hs0 = hs_count;
      applyStimulus(2, 3, 0, 1);
      for (int i = 0; i < 8; i++) begin
         m_ready = ready_pat[i];
         tick(1);
      end
      m_ready = 1'b1;
      waitIdle(50);
      checkOutput("t2_handshakes", 32'(hs_count - hs0), 6);

      $display("[TB] invalid dimensions");
      applyStimulus(2, 0, 0, 0);
      checkOutput("t3_err_dim_w0", 32'(err_dim), 1);
      checkOutput("t3_busy_w0", 32'(busy), 0);
      tick(3);
      checkOutput("t3_valid_w0", 32'(m_valid), 0);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      checkOutput("t3_err_dim_clr", 32'(err_dim), 0);
      applyStimulus(33, 2, 0, 0);
      checkOutput("t3_err_dim_h33", 32'(err_dim), 1);
      checkOutput("t3_valid_h33", 32'(m_valid), 0);
      err_clr = 1'b1;
      tick(1);
      checkOutput("t3_err_dim_clr2", 32'(err_dim), 0);
      applyStimulus(33, 2, 0, 0);
      err_clr = 1'b0;
      checkOutput("t3_set_wins", 32'(err_dim), 1);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      checkOutput("t3_err_dim_clr3", 32'(err_dim), 0);

      $display("[TB] overrun");
      applyStimulus(4, 4, 2, 1);
      tick(2);
      checkOutput("t4_beat2_data", 32'(m_data), 32'(mapVal(2, 0, 2)));
      applyStimulus(2, 2, 0, 0);
      checkOutput("t4_err_overrun", 32'(err_overrun), 1);
      checkOutput("t4_err_dim", 32'(err_dim), 0);
      waitIdle(60);

      $display("[TB] back-to-back maps");
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      checkOutput("t5_overrun_clr", 32'(err_overrun), 0);
      fc0 = frame_count;
      applyStimulus(2, 3, 0, 1);
      for (int n = 0; n < 20 && !m_last; n++) tick(1);
      checkOutput("t5_reach_last", 32'(m_last), 1);
      applyStimulus(1, 1, 1, 1);
      checkOutput("t5_next_valid", 32'(m_valid), 1);
      checkOutput("t5_next_data", 32'(m_data), 'hA5);
      checkOutput("t5_next_last", 32'(m_last), 1);
      checkOutput("t5_frame_done", 32'(frame_done), 1);
      checkOutput("t5_no_overrun", 32'(err_overrun), 0);
      waitIdle(20);
      checkOutput("t5_frame_count", 32'(frame_count - fc0), 2);

      $display("[TB] reset mid-stream");
      applyStimulus(8, 8, 0, 1);
      tick(5);
      checkOutput("t6_beat5_data", 32'(m_data), 5);
      rst_n = 1'b0;
      #1;
      checkOutput("t6_rst_valid", 32'(m_valid), 0);
      checkOutput("t6_rst_last", 32'(m_last), 0);
      checkOutput("t6_rst_data", 32'(m_data), 0);
      checkOutput("t6_rst_busy", 32'(busy), 0);
      checkOutput("t6_rst_frame_done", 32'(frame_done), 0);
      sb.delete();
      tick(2);
      rst_n = 1'b1;
      tick(3);
      checkOutput("t6_idle_busy", 32'(busy), 0);
      checkOutput("t6_idle_valid", 32'(m_valid), 0);
      applyStimulus(2, 2, 0, 1);
      checkOutput("t6_restart_valid", 32'(m_valid), 1);
      checkOutput("t6_restart_data", 32'(m_data), 0);
      waitIdle(20);

      checkOutput("sb_empty", 32'(sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/feature_map_streamer.md
Name: feature_map_streamer

Overview:
- Drain-side companion to the pooling layer's wide parallel output. It captures one feature map from the `valid_out`/`data_out` bus in a single cycle.
- It then streams the map out as one element per beat on a valid/ready interface, row-major, with `m_last` on the final element.
- This lets the testbench, or a narrow downstream layer, consume results without a full-width bus.

Parameters:
ELEM_WIDTH, 8, bits per feature-map element
MAX_IMG_HEIGHT, 32, maximum rows held in the capture buffer
MAX_IMG_WIDTH, 32, maximum columns; row stride of the packed input vector

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
cap_valid  input  1  single-cycle pulse; `cap_data` holds a complete map
cap_data  input  MAX_IMG_HEIGHT*MAX_IMG_WIDTH*ELEM_WIDTH  packed map; element (r,c) at bits [(r*MAX_IMG_WIDTH+c)*ELEM_WIDTH +: ELEM_WIDTH]
cap_height  input  8  valid rows in this map
cap_width  input  8  valid columns in this map
m_valid  output  1  stream element valid
m_ready  input  1  downstream accepts element
m_data  output  ELEM_WIDTH  stream element
m_last  output  1  high with the final element of the map
busy  output  1  high while a map is held or streaming
frame_done  output  1  one-cycle pulse after the last-element handshake
err_dim  output  1  sticky: a capture had a zero or oversized dimension
err_overrun  output  1  sticky: `cap_valid` arrived while busy
err_clr  input  1  synchronous clear of both sticky error flags

Behaviour:
- **Clock and reset:**
  - Single clock `clk`. Reset is asynchronous, active-low `rst_n`.
  - On reset, all outputs are 0, the state is IDLE, and the row/col counters are 0. The buffer contents are don't-care.
- **States:** IDLE and STREAM.
- **IDLE:**
  - `cap_valid`=1 with 1<=`cap_height`<=MAX_IMG_HEIGHT and 1<=`cap_width`<=MAX_IMG_WIDTH:
    - Latch `cap_data`, `cap_height` and `cap_width`; set row=col=0.
    - Go to STREAM with `m_valid`=1 and `m_data`=element (0,0) the next cycle. Latency from capture to first beat is one cycle.
  - `cap_valid`=1 with an invalid dimension: set `err_dim`, stay in IDLE, emit no beats.
- **STREAM:**
  - `m_data` = buffer element (row,col).
  - `m_last` = (row==h-1 && col==w-1).
  - `busy`=1.
  - Handshake occurs when `m_valid`&&`m_ready`:
    - col increments.
    - At col==w-1, col wraps to 0 and row increments.
  - No handshake: `m_valid`, `m_data` and `m_last` hold stable. `m_valid` is never withdrawn before acceptance.
  - Handshake on the `m_last` beat:
    - Pulse `frame_done` the next cycle and return to IDLE.
    - `m_valid` is 0 the next cycle unless a new capture is accepted.
- **Stream protocol:**
  - `m_valid` does not depend combinationally on `m_ready`.
  - `m_ready` may toggle arbitrarily; a back-to-back throughput of one element per cycle is required.
- **Overrun:**
  - `cap_valid` in STREAM (other than the final-handshake cycle) sets `err_overrun`.
  - The capture is ignored; the held map and stream continue unaffected.
- **Simultaneous capture and last handshake:**
  - `cap_valid` in the same cycle as the `m_last` handshake is accepted, since the buffer is freed.
  - The next map's element (0,0) appears the following cycle.
  - `frame_done` still pulses; no overrun is flagged.
- **Error flags:**
  - `err_clr` clears both flags.
  - If `err_clr` coincides with a new error event, the error set wins.
- **Reset mid-stream:** aborts immediately. There is no partial `frame_done` and no `m_last`; after reset the block is idle.
- **Dimensions:**
  - 1x1 map: a single beat with `m_last`=1.
  - Counters are 8 bits wide. Element index = row*MAX_IMG_WIDTH+col, so the row stride is fixed regardless of `cap_width`.

Decomposition:
- Shared package (reused by a future conv/FC streamer):
  - state enum {IDLE, STREAM}
  - `ELEM_IDX(r,c,W)` index function
  - `DIM_W`=8 constant
- One natural sub-module: `fm_elem_select`, a combinational mux that picks element (row,col) from the held buffer. It keeps the wide mux separate from the FSM/counter logic.

Test Plan:
- **Basic 2x3 map:** `cap_height`=2, `cap_width`=3, elements (r,c)=10*r+c, `m_ready`=1.
  - Beats 0,1,2,10,11,12 on consecutive cycles starting one cycle after `cap_valid`.
  - `m_last` only on 12; `frame_done` one cycle after.
- **Backpressure:** same map with `m_ready` pattern 1,0,0,1,0,1,1,1...
  - Identical data order.
  - `m_data`/`m_last` stable during every stall; exactly 6 handshakes.
- **Invalid dimensions:** `cap_width`=0, then `cap_height`=33.
  - `err_dim`=1, `m_valid` never asserted, `busy`=0.
  - `err_clr` returns `err_dim` to 0.
- **Overrun:** `cap_valid` pulsed at beat 2 of a 4x4 stream with different data.
  - `err_overrun`=1; all 16 beats are the original map.
- **Back-to-back maps:** second `cap_valid` coincident with the first map's `m_last` handshake; 1x1 map of value 0xA5.
  - No overrun; next cycle `m_data`=0xA5, `m_last`=1; two `frame_done` pulses in total.
- **Reset mid-stream:** `rst_n` low at beat 5 of an 8x8 stream.
  - Outputs are 0 immediately (asynchronous).
  - After release the block stays idle until a new capture, whose first beat is element (0,0).
